// File: rtl/rr_arbiter_model.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// A held grant is never preempted; the last-served requester gets lowest priority.

module rr_arbiter_model_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] gnt
);

  // At most one grant may be high in any cycle.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

module rr_arbiter_model (
  input  logic clk,
  input  logic rstn,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  output logic gnt0,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3
);

  logic [3:0] req_s;
  logic [3:0] gnt_r;
  logic [3:0] gnt_nxt_s;
  logic [1:0] last_r;
  logic [1:0] last_nxt_s;
  logic       hold_s;
  logic [2:0] pick_s;

  // Returns {found, index} of the first requester after last, wrapping to last itself.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_in, input logic [1:0] last_in);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = last_in + k[1:0] + 2'd1;
      if (req_in[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign req_s  = {req3, req2, req1, req0};
  assign hold_s = |(gnt_r & req_s);
  assign pick_s = rr_pick(req_s, last_r);

  // Next grant: hold while the grantee still requests, otherwise rotate.
  always_comb begin
    gnt_nxt_s  = gnt_r;
    last_nxt_s = last_r;
    if (hold_s) begin
      gnt_nxt_s  = gnt_r;
      last_nxt_s = last_r;
    end else if (pick_s[2]) begin
      gnt_nxt_s  = 4'b0001 << pick_s[1:0];
      last_nxt_s = pick_s[1:0];
    end else begin
      gnt_nxt_s  = 4'b0000;
      last_nxt_s = last_r;
    end
  end

  // Grant and last-served state; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      gnt_r  <= 4'b0000;
      last_r <= 2'd3;
    end else begin
      gnt_r  <= gnt_nxt_s;
      last_r <= last_nxt_s;
    end
  end

  assign gnt0 = gnt_r[0];
  assign gnt1 = gnt_r[1];
  assign gnt2 = gnt_r[2];
  assign gnt3 = gnt_r[3];

  rr_arbiter_model_chk u_chk (
    .clk (clk),
    .rst (rstn),
    .gnt (gnt_r)
  );

endmodule

// File: tb/tb_rr_arbiter_model.sv
// Self-checking bench for rr_arbiter_model: reset checks, a vector table
// through a scoreboard queue, and hand-written hold/reset sequences.

module tb_rr_arbiter_model;

  logic clk;
  logic rstn;
  logic req0, req1, req2, req3;
  logic gnt0, gnt1, gnt2, gnt3;
  logic [3:0] gnt_v;

  int total;
  int bad;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t tbl[22];
  logic [3:0] exp_q[$];

  rr_arbiter_model dut (
    .clk  (clk),
    .rstn (rstn),
    .req0 (req0),
    .req1 (req1),
    .req2 (req2),
    .req3 (req3),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .gnt2 (gnt2),
    .gnt3 (gnt3)
  );

  assign gnt_v = {gnt3, gnt2, gnt1, gnt0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: gnt=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    {req3, req2, req1, req0} = r;
  endtask

  // Drive one request pattern, queue its expected grant, compare after the edge.
  task automatic step(input string name, input logic [3:0] r, input logic [3:0] exp);
    logic [3:0] e;
    @(negedge clk);
    set_req(r);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, gnt_v, e);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // req pattern -> grant visible after the following edge
    tbl[0]  = '{4'b0000, 4'b0000};  // idle after reset release
    tbl[1]  = '{4'b0001, 4'b0001};  // single request, one-cycle latency
    tbl[2]  = '{4'b0010, 4'b0010};  // handoff 0 -> 1
    tbl[3]  = '{4'b0101, 4'b0100};  // rotation skips lower index 0
    tbl[4]  = '{4'b1001, 4'b1000};
    tbl[5]  = '{4'b0011, 4'b0001};  // wrap 3 -> 0
    tbl[6]  = '{4'b0010, 4'b0010};
    tbl[7]  = '{4'b0000, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b1111, 4'b0100};  // hold, no preemption x5
    tbl[10] = '{4'b1111, 4'b0100};
    tbl[11] = '{4'b1111, 4'b0100};
    tbl[12] = '{4'b1111, 4'b0100};
    tbl[13] = '{4'b1111, 4'b0100};
    tbl[14] = '{4'b1011, 4'b1000};  // release 2 -> 3
    tbl[15] = '{4'b1011, 4'b1000};
    tbl[16] = '{4'b0011, 4'b0001};
    tbl[17] = '{4'b0011, 4'b0001};
    tbl[18] = '{4'b0010, 4'b0010};
    tbl[19] = '{4'b0000, 4'b0000};
    tbl[20] = '{4'b0010, 4'b0010};  // sole requester regranted after release
    tbl[21] = '{4'b0010, 4'b0010};

    rstn = 1'b1;
    set_req(4'b0000);
    #1;
    check("reset_t0", gnt_v, 4'b0000);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_req(4'($urandom_range(0, 15)));
      @(posedge clk);
      #1;
      check("reset_hold", gnt_v, 4'b0000);
    end

    @(negedge clk);
    rstn = 1'b0;
    set_req(4'b0000);

    for (int i = 0; i < 22; i++) begin
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].gnt);
    end

    // Reset pulse between edges while gnt1 is held.
    check("pre_rst_gnt1", gnt_v, 4'b0010);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("rst_async_clear", gnt_v, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_held_clear", gnt_v, 4'b0000);
    @(negedge clk);
    rstn = 1'b0;
    step("rst_restart_prio", 4'b1010, 4'b0010);
    step("after_rst_handoff", 4'b1000, 4'b1000);
    step("final_idle", 4'b0000, 4'b0000);

    check("scoreboard_drained", 4'(exp_q.size()), 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_model.md
# rr_arbiter_model

Four-requester round-robin arbiter with registered, one-hot grants. It sits between four bus masters and a shared resource. It grants exactly one active requester at a time and holds that grant for as long as the requester keeps asserting its request. It rotates priority so that the most recently served requester has the lowest priority in the next arbitration.

## Interface
- No parameters; requester count fixed at 4.
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  asynchronous reset, active-high (asserted = 1); name retained from codebase convention.
- req0  input  1  request from requester 0; level-sensitive.
- req1  input  1  request from requester 1.
- req2  input  1  request from requester 2.
- req3  input  1  request from requester 3.
- gnt0  output  1  grant to requester 0; registered.
- gnt1  output  1  grant to requester 1; registered.
- gnt2  output  1  grant to requester 2; registered.
- gnt3  output  1  grant to requester 3; registered.

## Operation
- State:
  - grant register gnt[3:0], one-hot or all-zero;
  - last-served pointer last[1:0].
- Reset (rstn=1, asynchronous): gnt=4'b0000 and last=2'd3, so requester 0 has highest priority after reset. Outputs stay 0 for the whole time reset is asserted.
- Each rising edge with reset deasserted:
  - Hold: if a grant is active and the granted requester's req is still 1, keep the grant unchanged and leave last unchanged.
  - Re-arbitrate: otherwise (no grant, or the granted req dropped), search requesters in order last+1, last+2, last+3, last+4 (mod 4). Grant the first one with req=1 and set last to its index.
  - The requester that just released is searched last. It can be regranted only if it is the sole requester.
- No requests at re-arbitration: gnt=0000 and last is unchanged.
- Grant never goes to a requester whose req was 0 at the sampling edge.
- Preemption: a higher-priority request never preempts an active, held grant.
- Handoff: when the grantee drops req and others are pending, the new grant appears on the same edge the drop is sampled. There is no idle cycle.
- X/undefined req inputs are outside the contract. A bench must drive all req to known values before first use.

## Timing
- Latency: a request sampled at edge N with the arbiter idle produces gnt=1 immediately after edge N (one-cycle registered latency).
- Release: req deasserted before edge N clears or moves the grant at edge N.
- Outputs are glitch-free flop outputs; no combinational path from req to gnt.
- At most one gnt is high in any cycle, including the cycle immediately after reset release.
- Reset asserted mid-grant clears all gnt asynchronously and reinitialises last=3. After release, priority restarts at requester 0.
- Reset release: the first arbitration happens on the first rising edge after rstn falls.

## Test plan
- Reset: hold rstn=1 for 10 cycles with arbitrary req. Required: gnt3..0=0000 throughout. After release with all req=0, gnt stays 0000.
- Single request: req0=1 only -> gnt0=1 one edge later. Then req0=0, req1=1 -> gnt1=1 and gnt0=0 on the next edge.
- Rotation past lower index: after gnt1, drive req0=1 and req2=1 (req1=0) -> gnt2=1 (not gnt0).
- Continuing the rotation:
  - keep req0=1, set req2=0, req3=1 -> gnt3=1;
  - then req3=0, req1=1 with req0 still 1 -> gnt0=1 (wrap-around from 3 to 0);
  - then req0=0 -> gnt1=1.
- Hold and no preemption: grant req2 alone, then raise req0, req1, req3 while req2 stays 1 for 5 cycles. Required: gnt2 stays 1 for all 5 cycles. On req2=0 -> gnt3=1 on the next edge.
- Reset mid-grant: with gnt1=1, pulse rstn=1 between clock edges. Required: gnt immediately 0000. After release with req1=1 and req3=1 -> gnt1=1 first, since priority restarts at requester 0.
